// File: rtl/ring_osc_freq_meter.sv
// Gated-window frequency meter for pre-divided ring-oscillator taps.
// One tap is selected, synchronised into clk and its rising edges are counted
// over a 2^G-cycle gate. The count is presented on a valid/ready result port.
module ring_osc_freq_meter #(
  parameter  int NCH           = 4,
  parameter  int CNT_W         = 16,
  parameter  int GATE_MAX_LOG2 = 16,
  parameter  int SETTLE_CYC    = 4,
  localparam int CH_W          = $clog2(NCH),
  localparam int GL_W          = $clog2(GATE_MAX_LOG2 + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   osc_in,
  input  logic [CH_W-1:0]  ch_sel,
  input  logic [GL_W-1:0]  gate_log2,
  input  logic             start,
  input  logic             continuous,
  output logic [CNT_W-1:0] result,
  output logic [CH_W-1:0]  result_ch,
  output logic             result_ovf,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy
);

  localparam int GC_W = GATE_MAX_LOG2 + 1;
  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [GL_W-1:0] G_CLAMP = GL_W'(GATE_MAX_LOG2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_GATE   = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_nextState;

  logic [CH_W-1:0]   r_chLat;
  logic [GL_W-1:0]   r_gLog2;
  logic              r_s1;
  logic              r_s2;
  logic              r_s3;
  logic [SC_W-1:0]   r_settleCnt;
  logic [GC_W-1:0]   r_gateCnt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;
  logic [CNT_W-1:0]  r_result;
  logic [CH_W-1:0]   r_resultCh;
  logic              r_resultOvf;
  logic              r_valid;

  logic              w_oscSel;
  logic              w_rise;
  logic              w_settleDone;
  logic [GC_W-1:0]   w_gateLen;
  logic [GC_W-1:0]   w_gateLast;
  logic              w_gateDone;
  logic              w_cntFull;
  logic [CNT_W-1:0]  w_cntNext;
  logic              w_ovfNext;
  logic              w_handshake;
  logic              w_enterSettle;

  // Tap mux: an index beyond the last channel reads as a constant 0.
  always_comb begin
    w_oscSel = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (r_chLat == CH_W'(i)) begin
        w_oscSel = osc_in[i];
      end
    end
  end

  assign w_rise       = r_s2 & ~r_s3;
  assign w_settleDone = (r_settleCnt == SC_W'(SETTLE_CYC - 1));
  assign w_gateLen    = GC_W'(1) << r_gLog2;
  assign w_gateLast   = w_gateLen - GC_W'(1);
  assign w_gateDone   = (r_gateCnt == w_gateLast);
  assign w_cntFull    = &r_cnt;
  assign w_cntNext    = (w_rise && !w_cntFull) ? (r_cnt + CNT_W'(1)) : r_cnt;
  assign w_ovfNext    = r_ovf | (w_rise & w_cntFull);
  assign w_handshake  = r_valid & result_ready;
  assign w_enterSettle = ((r_state == S_IDLE) && start) ||
                         ((r_state == S_HOLD) && w_handshake && continuous);

  // Next-state logic for the measurement sequence.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (start) w_nextState = S_SETTLE;
      S_SETTLE: if (w_settleDone) w_nextState = S_GATE;
      S_GATE:   if (w_gateDone) w_nextState = S_HOLD;
      S_HOLD: begin
        if (w_handshake) begin
          w_nextState = continuous ? S_SETTLE : S_IDLE;
        end
      end
      default:  w_nextState = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  // Two-flop synchroniser plus a history flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= w_oscSel;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Channel and gate exponent are captured only when a measurement begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chLat <= '0;
      r_gLog2 <= '0;
    end else if (w_enterSettle) begin
      r_chLat <= ch_sel;
      r_gLog2 <= (gate_log2 > G_CLAMP) ? G_CLAMP : gate_log2;
    end
  end

  // Settle and gate cycle counters run only in their own state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_settleCnt <= '0;
      r_gateCnt   <= '0;
    end else begin
      if ((r_state == S_SETTLE) && !w_settleDone) r_settleCnt <= r_settleCnt + SC_W'(1);
      else                                        r_settleCnt <= '0;
      if ((r_state == S_GATE) && !w_gateDone)     r_gateCnt <= r_gateCnt + GC_W'(1);
      else                                        r_gateCnt <= '0;
    end
  end

  // Edge counter: cleared while settling, saturating count during the gate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (r_state == S_SETTLE) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (r_state == S_GATE) begin
      r_cnt <= w_cntNext;
      r_ovf <= w_ovfNext;
    end
  end

  // Result registers load with the final gate cycle's edge included; valid drops after handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result    <= '0;
      r_resultCh  <= '0;
      r_resultOvf <= 1'b0;
      r_valid     <= 1'b0;
    end else if ((r_state == S_GATE) && w_gateDone) begin
      r_result    <= w_cntNext;
      r_resultCh  <= r_chLat;
      r_resultOvf <= w_ovfNext;
      r_valid     <= 1'b1;
    end else if (w_handshake) begin
      r_valid     <= 1'b0;
    end
  end

  assign result       = r_result;
  assign result_ch    = r_resultCh;
  assign result_ovf   = r_resultOvf;
  assign result_valid = r_valid;
  assign busy         = (r_state != S_IDLE);

endmodule
